// File: rtl/traffic_light_pkg.sv
// Shared definitions for the intersection lamp interface: lamp codes, phase
// encodings, monitor states, dwell-counter ops and default minimum dwells.
package traffic_light_pkg;

  localparam int unsigned LAMP_W  = 4;
  localparam int unsigned PHASE_W = 2;

  localparam logic [LAMP_W-1:0] LAMP_RED = 4'b1000;
  localparam logic [LAMP_W-1:0] LAMP_YEL = 4'b0100;
  localparam logic [LAMP_W-1:0] LAMP_GRN = 4'b0010;
  localparam logic [LAMP_W-1:0] LAMP_OFF = 4'b1111;

  localparam logic [PHASE_W-1:0] PH_RED  = 2'b00;
  localparam logic [PHASE_W-1:0] PH_YEL  = 2'b01;
  localparam logic [PHASE_W-1:0] PH_GRN  = 2'b10;
  localparam logic [PHASE_W-1:0] PH_NONE = 2'b11;

  // Minimum dwell defaults, shared with the controller
  localparam int unsigned DEF_RED_MIN = 10;
  localparam int unsigned DEF_YEL_MIN = 1;
  localparam int unsigned DEF_GRN_MIN = 4;
  localparam int unsigned DEF_CNT_W   = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RED,
    ST_YEL,
    ST_GRN,
    ST_FAULT
  } mon_state_e;

  typedef enum logic [1:0] {
    CNT_HOLD,
    CNT_ZERO,
    CNT_ONE,
    CNT_INC
  } cnt_op_e;

  // Phase shown on the output for a given monitor state
  function automatic logic [PHASE_W-1:0] state_to_phase(input mon_state_e s);
    case (s)
      ST_RED:  return PH_RED;
      ST_YEL:  return PH_YEL;
      ST_GRN:  return PH_GRN;
      default: return PH_NONE;
    endcase
  endfunction

  // Colour state for a lamp code; non-colour codes map to FAULT
  function automatic mon_state_e lamp_to_state(input logic [LAMP_W-1:0] code);
    case (code)
      LAMP_RED: return ST_RED;
      LAMP_YEL: return ST_YEL;
      LAMP_GRN: return ST_GRN;
      default:  return ST_FAULT;
    endcase
  endfunction

endpackage

// File: rtl/traffic_sat_counter.sv
// Saturating up-counter with clear-to-0, clear-to-1, increment and hold.
// Ports: i_clk, i_rst (async, active-high), i_op (counter operation),
//        o_count (current value, sticks at all-ones).
module traffic_sat_counter
  import traffic_light_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  cnt_op_e      i_op,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else begin
      case (i_op)
        CNT_ZERO: r_count <= '0;
        CNT_ONE:  r_count <= W'(1);
        CNT_INC:  if (r_count != '1) r_count <= r_count + W'(1);
        default:  r_count <= r_count;
      endcase
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/traffic_light_monitor.sv
// Lamp-bus monitor: registers the one-hot lamp bus, decodes the phase, tracks
// per-phase dwell and flags order, short-dwell and illegal-code errors.
// Ports: clk, res (async, active-high), en (0 freezes state), lamp (bus in),
//        err_clr (clears err_sticky); phase, dwell, cycle_cnt, seq_err,
//        short_err, code_err (1-cycle pulses), err_sticky.
module traffic_light_monitor
  import traffic_light_pkg::*;
#(
  parameter int unsigned RED_MIN = DEF_RED_MIN,
  parameter int unsigned YEL_MIN = DEF_YEL_MIN,
  parameter int unsigned GRN_MIN = DEF_GRN_MIN,
  parameter int unsigned CNT_W   = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               res,
  input  logic               en,
  input  logic [LAMP_W-1:0]  lamp,
  input  logic               err_clr,
  output logic [PHASE_W-1:0] phase,
  output logic [CNT_W-1:0]   dwell,
  output logic [15:0]        cycle_cnt,
  output logic               seq_err,
  output logic               short_err,
  output logic               code_err,
  output logic               err_sticky
);

  mon_state_e          r_state;
  mon_state_e          w_state_nxt;
  mon_state_e          w_lamp_st;
  logic [LAMP_W-1:0]   r_lamp_q;
  logic [LAMP_W-1:0]   r_fault_code;
  logic [LAMP_W-1:0]   w_fault_code_nxt;
  logic [PHASE_W-1:0]  r_phase;
  logic [15:0]         r_cycle_cnt;
  logic                r_seq_err;
  logic                r_short_err;
  logic                r_code_err;
  logic                r_err_sticky;
  logic                w_seq_nxt;
  logic                w_short_nxt;
  logic                w_code_nxt;
  logic                w_cycle_inc;
  logic                w_is_succ;
  logic [31:0]         w_old_min;
  logic [CNT_W-1:0]    w_dwell;
  cnt_op_e             w_cnt_op;

  // Dwell counter
  traffic_sat_counter #(.W(CNT_W)) u_dwell (
    .i_clk   (clk),
    .i_rst   (res),
    .i_op    (w_cnt_op),
    .o_count (w_dwell)
  );

  // State register
  always_ff @(posedge clk or posedge res) begin
    if (res) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state, counter op and error decisions, all from the registered lamp
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_op         = CNT_HOLD;
    w_seq_nxt        = 1'b0;
    w_short_nxt      = 1'b0;
    w_code_nxt       = 1'b0;
    w_cycle_inc      = 1'b0;
    w_fault_code_nxt = r_fault_code;
    w_lamp_st        = lamp_to_state(r_lamp_q);
    w_is_succ        = (r_state == ST_RED && w_lamp_st == ST_YEL) ||
                       (r_state == ST_YEL && w_lamp_st == ST_GRN) ||
                       (r_state == ST_GRN && w_lamp_st == ST_RED);
    case (r_state)
      ST_RED:  w_old_min = 32'(RED_MIN);
      ST_YEL:  w_old_min = 32'(YEL_MIN);
      ST_GRN:  w_old_min = 32'(GRN_MIN);
      default: w_old_min = 32'd0;
    endcase

    if (en) begin
      if (r_lamp_q == LAMP_OFF) begin
        w_state_nxt = ST_IDLE;
        w_cnt_op    = CNT_ZERO;
      end else if (w_lamp_st == ST_FAULT) begin
        // Pulse once per distinct illegal code while faulted
        w_state_nxt      = ST_FAULT;
        w_cnt_op         = CNT_ZERO;
        w_fault_code_nxt = r_lamp_q;
        w_code_nxt       = (r_state != ST_FAULT) || (r_lamp_q != r_fault_code);
      end else begin
        case (r_state)
          ST_RED, ST_YEL, ST_GRN: begin
            if (w_lamp_st == r_state) begin
              w_cnt_op = CNT_INC;
            end else begin
              // Any colour change resynchronises to the new colour
              w_state_nxt = w_lamp_st;
              w_cnt_op    = CNT_ONE;
              if (w_is_succ) begin
                w_short_nxt = 32'(w_dwell) < w_old_min;
                w_cycle_inc = (r_state == ST_GRN);
              end else begin
                w_seq_nxt = 1'b1;
              end
            end
          end
          default: begin
            w_state_nxt = w_lamp_st;
            w_cnt_op    = CNT_ONE;
          end
        endcase
      end
    end
  end

  // Input stage, phase, counters and error flags
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_lamp_q     <= LAMP_OFF;
      r_fault_code <= LAMP_OFF;
      r_phase      <= PH_NONE;
      r_cycle_cnt  <= 16'd0;
      r_seq_err    <= 1'b0;
      r_short_err  <= 1'b0;
      r_code_err   <= 1'b0;
      r_err_sticky <= 1'b0;
    end else begin
      if (en) r_lamp_q <= lamp;
      r_fault_code <= w_fault_code_nxt;
      r_phase      <= state_to_phase(w_state_nxt);
      if (w_cycle_inc) r_cycle_cnt <= r_cycle_cnt + 16'd1;
      r_seq_err    <= w_seq_nxt;
      r_short_err  <= w_short_nxt;
      r_code_err   <= w_code_nxt;
      // A visible pulse sets the flag even when err_clr is high
      r_err_sticky <= r_seq_err | r_short_err | r_code_err |
                      (r_err_sticky & ~err_clr);
    end
  end

  assign phase      = r_phase;
  assign dwell      = w_dwell;
  assign cycle_cnt  = r_cycle_cnt;
  assign seq_err    = r_seq_err;
  assign short_err  = r_short_err;
  assign code_err   = r_code_err;
  assign err_sticky = r_err_sticky;

endmodule
